// File: rtl/alu16bit_div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Sign/Zero/Parity are taken from the registered quotient.
module alu16bit_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] R,
  output logic             Busy,
  output logic             Done,
  output logic             Sign,
  output logic             Zero,
  output logic             Parity,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             divz_q, divz_d;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   trial;

  // Partial remainder always stays below the divisor, so the 17-bit shift never loses data.
  assign p_sh  = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial = p_sh - {1'b0, d_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      z_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      z_q     <= z_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      divz_q  <= divz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    z_d     = z_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    divz_d  = divz_q;

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          q_d    = X;
          d_d    = Y;
          p_d    = '0;
          cnt_d  = '0;
          divz_d = (Y == '0);
          if (Y == '0) begin
            z_d     = '1;
            r_d     = X;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // Negative trial (borrow out) restores the shifted remainder.
        p_d   = trial[WIDTH] ? p_sh : trial;
        q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          z_d     = q_d;
          r_d     = p_d[WIDTH-1:0];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Z       = z_q;
  assign R       = r_q;
  assign Busy    = (state_q == BUSY);
  assign Done    = (state_q == DONE);
  assign DivZero = divz_q;
  assign Sign    = z_q[WIDTH-1];
  assign Zero    = (z_q == '0);
  assign Parity  = ~^z_q;

endmodule

// File: tb/tb_alu16bit_div_seq.sv
// Self-checking bench for alu16bit_div_seq: directed table, corner sequences, random regression.
module tb_alu16bit_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic [15:0] X, Y, Z, R;
  logic        Busy, Done, Sign, Zero, Parity, DivZero;

  always #5 clk = ~clk;

  alu16bit_div_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .X(X), .Y(Y),
    .Z(Z), .R(R), .Busy(Busy), .Done(Done),
    .Sign(Sign), .Zero(Zero), .Parity(Parity), .DivZero(DivZero)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [15:0] r;
    logic        dz;
  } vec_t;

  vec_t        sb[$];
  vec_t        tbl[6];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] last_z = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] x, y, z, r, input logic dz);
    vec_t v;
    v.x = x; v.y = y; v.z = z; v.r = r; v.dz = dz;
    return v;
  endfunction

  // Drive one Start pulse; leaves the bench at the negedge after the capture edge.
  task automatic start_op(input vec_t v, input bit push);
    @(negedge clk);
    Start = 1'b1;
    X     = v.x;
    Y     = v.y;
    if (push) sb.push_back(v);
    @(negedge clk);
    Start = 1'b0;
    chk("busy_at_capture", 32'(Busy), 32'(v.y != 16'h0));
    chk("done_at_capture", 32'(Done), 32'(v.y == 16'h0));
  endtask

  task automatic wait_done(input int lat0);
    int   lat;
    vec_t e;
    lat = lat0;
    while (!Done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 8) chk("z_hold_while_busy", 32'(Z), 32'(last_z));
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got Done with no expected result queued");
      return;
    end
    e = sb.pop_front();
    chk("latency", lat, e.dz ? 0 : 16);
    chk("Z", 32'(Z), 32'(e.z));
    chk("R", 32'(R), 32'(e.r));
    chk("DivZero", 32'(DivZero), 32'(e.dz));
    chk("Sign", 32'(Sign), 32'(e.z[15]));
    chk("Zero", 32'(Zero), 32'(e.z == 16'h0));
    chk("Parity", 32'(Parity), 32'(~^e.z));
    chk("busy_at_done", 32'(Busy), 32'd0);
    last_z = e.z;
  endtask

  initial begin
    vec_t        v;
    logic [15:0] rx, ry;

    tbl[0] = mk(16'd100,   16'd7,      16'd14,    16'd2,    1'b0);
    tbl[1] = mk(16'hFFFF,  16'd1,      16'hFFFF,  16'd0,    1'b0);
    tbl[2] = mk(16'h8000,  16'h0002,   16'h4000,  16'd0,    1'b0);
    tbl[3] = mk(16'd5,     16'd9,      16'd0,     16'd5,    1'b0);
    tbl[4] = mk(16'h1234,  16'd0,      16'hFFFF,  16'h1234, 1'b1);
    tbl[5] = mk(16'd20,    16'd4,      16'd5,     16'd0,    1'b0);

    rst_n = 1'b0;
    Start = 1'b0;
    X     = 16'h0;
    Y     = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_Z", 32'(Z), 32'd0);
    chk("rst_R", 32'(R), 32'd0);
    chk("rst_Busy", 32'(Busy), 32'd0);
    chk("rst_Done", 32'(Done), 32'd0);
    chk("rst_flags", {28'd0, Sign, Zero, Parity, DivZero}, 32'b0110);
    rst_n = 1'b1;

    // Table entries run back-to-back, so each Start after the first lands in DONE.
    for (int i = 0; i < 6; i++) begin
      start_op(tbl[i], 1'b1);
      wait_done(0);
    end

    // Start while busy must be ignored.
    start_op(mk(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0), 1'b1);
    repeat (4) @(negedge clk);
    Start = 1'b1;
    X     = 16'd9;
    Y     = 16'd9;
    @(negedge clk);
    Start = 1'b0;
    chk("busy_after_ignored_start", 32'(Busy), 32'd1);
    wait_done(5);

    // Asynchronous reset mid-division aborts everything.
    start_op(mk(16'd500, 16'd10, 16'd50, 16'd0, 1'b0), 1'b0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_Busy", 32'(Busy), 32'd0);
    chk("abort_Done", 32'(Done), 32'd0);
    chk("abort_Z", 32'(Z), 32'd0);
    chk("abort_R", 32'(R), 32'd0);
    chk("abort_flags", {28'd0, Sign, Zero, Parity, DivZero}, 32'b0110);
    @(negedge clk);
    rst_n  = 1'b1;
    last_z = 16'h0;
    start_op(mk(16'd500, 16'd10, 16'd50, 16'd0, 1'b0), 1'b1);
    wait_done(0);

    for (int n = 0; n < 400; n++) begin
      rx = 16'($urandom);
      ry = 16'($urandom_range(1, 65535));
      v  = mk(rx, ry, rx / ry, rx % ry, 1'b0);
      start_op(v, 1'b1);
      wait_done(0);
      chk("invariant", 32'(Z) * 32'(ry) + 32'(R), 32'(rx));
      chk("rem_below_div", 32'(R < ry), 32'd1);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
